// File: rtl/fsm_cmd_arbiter_if.sv
// Bundle of the requester-side and FSM-side signals of the command arbiter.
// The master modport is the environment (requesters plus the shared FSM).
// The slave modport is the arbiter itself.
interface fsm_cmd_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int CMD_W   = 3
) ();
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*CMD_W-1:0] cmd;
  logic [1:0]               fsm_state;
  logic [NUM_REQ-1:0]       gnt;
  logic [CMD_W-1:0]         fsm_cmd;
  logic                     fsm_cmd_vld;
  logic                     done;
  logic                     err;
  logic                     busy;

  modport master (
    output req, cmd, fsm_state,
    input  gnt, fsm_cmd, fsm_cmd_vld, done, err, busy
  );

  modport slave (
    input  req, cmd, fsm_state,
    output gnt, fsm_cmd, fsm_cmd_vld, done, err, busy
  );
endinterface

// File: rtl/fsm_cmd_arbiter.sv
// Round-robin arbiter that shares one mode FSM's command input among NUM_REQ
// requesters. The winner's command is driven for HOLD_CYCLES cycles, after which
// the FSM state is watched until it equals the command (done) or TIMEOUT WAIT
// cycles elapse (err). Commands above 3 cannot be represented by the 2-bit FSM
// state and are rejected straight away with err.
module fsm_cmd_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int CMD_W       = 3,
  parameter int HOLD_CYCLES = 2,
  parameter int TIMEOUT     = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  fsm_cmd_arbiter_if.slave bus
);
  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W  = IDX_W + 1;
  localparam int WCNT_W = $clog2(TIMEOUT + 1);
  localparam int HCNT_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_ISSUE   = 2'b01,
    S_WAIT    = 2'b10,
    S_RELEASE = 2'b11
  } state_t;

  state_t              r_state,  w_state_next;
  logic [IDX_W-1:0]    r_ptr,    w_ptr_next;
  logic [IDX_W-1:0]    r_win,    w_win_next;
  logic [CMD_W-1:0]    r_cmd_q,  w_cmd_q_next;
  logic [NUM_REQ-1:0]  r_gnt,    w_gnt_next;
  logic [HCNT_W-1:0]   r_hcnt,   w_hcnt_next;
  logic [WCNT_W-1:0]   r_wcnt,   w_wcnt_next;
  logic                r_ok,     w_ok_next;

  logic [CMD_W-1:0]    w_cmd_arr [NUM_REQ];
  logic                w_found;
  logic [IDX_W-1:0]    w_win_idx;
  logic [SUM_W-1:0]    w_sum;
  logic [IDX_W-1:0]    w_idx;

  // Split the flat command bus into one slice per requester.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cmd_slice
      assign w_cmd_arr[gi] = bus.cmd[gi*CMD_W +: CMD_W];
    end
  endgenerate

  // Round-robin search: first asserted request at or above the pointer, wrapping.
  always_comb begin
    w_found   = 1'b0;
    w_win_idx = '0;
    w_sum     = '0;
    w_idx     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_sum = {1'b0, r_ptr} + SUM_W'(off);
      if (w_sum >= SUM_W'(NUM_REQ)) begin
        w_sum = w_sum - SUM_W'(NUM_REQ);
      end
      w_idx = w_sum[IDX_W-1:0];
      if (!w_found && bus.req[w_idx]) begin
        w_found   = 1'b1;
        w_win_idx = w_idx;
      end
    end
  end

  // Controller state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_win   <= '0;
      r_cmd_q <= '0;
      r_gnt   <= '0;
      r_hcnt  <= '0;
      r_wcnt  <= '0;
      r_ok    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_win   <= w_win_next;
      r_cmd_q <= w_cmd_q_next;
      r_gnt   <= w_gnt_next;
      r_hcnt  <= w_hcnt_next;
      r_wcnt  <= w_wcnt_next;
      r_ok    <= w_ok_next;
    end
  end

  // Next-state logic: grant, hold the command, wait for the FSM, release.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_win_next   = r_win;
    w_cmd_q_next = r_cmd_q;
    w_gnt_next   = r_gnt;
    w_hcnt_next  = r_hcnt;
    w_wcnt_next  = r_wcnt;
    w_ok_next    = r_ok;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_win_next   = w_win_idx;
          w_cmd_q_next = w_cmd_arr[w_win_idx];
          w_gnt_next   = NUM_REQ'(1) << w_win_idx;
          w_hcnt_next  = '0;
          w_wcnt_next  = '0;
          w_ok_next    = 1'b0;
          // The FSM state is only 2 bits wide, so larger commands can never match.
          if (w_cmd_arr[w_win_idx] > CMD_W'(3)) begin
            w_state_next = S_RELEASE;
          end else begin
            w_state_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (r_hcnt == HCNT_W'(HOLD_CYCLES - 1)) begin
          w_hcnt_next  = '0;
          w_state_next = S_WAIT;
        end else begin
          w_hcnt_next = r_hcnt + HCNT_W'(1);
        end
      end
      S_WAIT: begin
        // A match on the last allowed cycle takes priority over the timeout.
        if (bus.fsm_state == r_cmd_q[1:0]) begin
          w_ok_next    = 1'b1;
          w_state_next = S_RELEASE;
        end else begin
          if (r_wcnt == WCNT_W'(TIMEOUT - 1)) begin
            w_state_next = S_RELEASE;
          end
          if (r_wcnt != WCNT_W'(TIMEOUT)) begin
            w_wcnt_next = r_wcnt + WCNT_W'(1);
          end
        end
      end
      S_RELEASE: begin
        w_state_next = S_IDLE;
        w_gnt_next   = '0;
        w_ptr_next   = (r_win == IDX_W'(NUM_REQ - 1)) ? '0 : r_win + IDX_W'(1);
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign bus.gnt         = r_gnt;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.fsm_cmd_vld = (r_state == S_ISSUE);
  assign bus.fsm_cmd     = (r_state == S_ISSUE) ? r_cmd_q : '0;
  assign bus.done        = (r_state == S_RELEASE) &&  r_ok;
  assign bus.err         = (r_state == S_RELEASE) && !r_ok;
endmodule

// File: tb/tb_fsm_cmd_arbiter.sv
// Scoreboard bench for fsm_cmd_arbiter: a driver pushes the expected outcome of
// each transaction (computed from the round-robin and timeout rules), and a
// monitor pops and compares whenever a grant completes.
module tb_fsm_cmd_arbiter;
  localparam int N    = 4;
  localparam int W    = 3;
  localparam int HOLD = 2;
  localparam int TO   = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fsm_cmd_arbiter_if #(.NUM_REQ(N), .CMD_W(W)) bus ();

  fsm_cmd_arbiter #(.NUM_REQ(N), .CMD_W(W), .HOLD_CYCLES(HOLD), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int win;
    int cmd;
    bit ok;
    int glen;
    int vlen;
    int start;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   model_ptr = 0;
  int   fsm_d   = 0;

  function automatic void check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Model of the shared FSM: it adopts the command fsm_d WAIT cycles late
  // (fsm_d = 0 means it follows fsm_cmd directly; a large fsm_d never matches).
  int         fcnt = 0;
  logic [1:0] ftgt = 2'd0;
  always @(posedge clk) begin
    if (bus.fsm_cmd_vld) begin
      fcnt <= 0;
      ftgt <= bus.fsm_cmd[1:0];
      bus.fsm_state <= (fsm_d == 0) ? bus.fsm_cmd[1:0] : ~bus.fsm_cmd[1:0];
    end else begin
      fcnt <= fcnt + 1;
      if (fcnt + 1 == fsm_d) bus.fsm_state <= ftgt;
    end
  end

  // Reference round robin: first request at or after the pointer, wrapping.
  function automatic int pick(input logic [N-1:0] r);
    for (int off = 0; off < N; off++) begin
      if (r[(model_ptr + off) % N]) return (model_ptr + off) % N;
    end
    return 0;
  endfunction

  task automatic push_txn(input logic [N-1:0] r, input logic [N*W-1:0] cv, input int d);
    exp_t e;
    int   w;
    w = pick(r);
    bus.req = r;
    bus.cmd = cv;
    fsm_d   = d;
    e.win   = w;
    e.cmd   = int'(cv[w*W +: W]);
    e.start = cyc + 1;
    if (e.cmd > 3) begin
      e.ok = 1'b0; e.glen = 1; e.vlen = 0;
    end else if (d + 1 <= TO) begin
      e.ok = 1'b1; e.glen = HOLD + (d + 1) + 1; e.vlen = HOLD;
    end else begin
      e.ok = 1'b0; e.glen = HOLD + TO + 1; e.vlen = HOLD;
    end
    exp_q.push_back(e);
    model_ptr = (w + 1) % N;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.busy && k < 4) begin @(negedge clk); k++; end
    check("busy_rise_bound", int'(bus.busy), 1);
    k = 0;
    while (bus.busy && k < 200) begin @(negedge clk); k++; end
    check("busy_fall_bound", int'(bus.busy), 0);
  endtask

  task automatic issue(input logic [N-1:0] r, input logic [N*W-1:0] cv, input int d);
    push_txn(r, cv, d);
    wait_done();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    model_ptr = 0;
    #1;
    check("rst_gnt",  int'(bus.gnt), 0);
    check("rst_vld",  int'(bus.fsm_cmd_vld), 0);
    check("rst_cmd",  int'(bus.fsm_cmd), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err",  int'(bus.err), 0);
    check("rst_busy", int'(bus.busy), 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: invariants every cycle, scoreboard compare at the end of each grant.
  exp_t        cur;
  bit          active = 1'b0;
  logic [N-1:0] gprev = '0;
  int          glen, vlen, npulse, ppos, st;
  bit          sdone, serr;
  always @(negedge clk) begin
    if (!rst_n) begin
      active = 1'b0;
      gprev  = '0;
    end else begin
      check("gnt_onehot", int'(bus.gnt == '0 || $onehot(bus.gnt)), 1);
      check("busy_vs_gnt", int'(bus.busy), int'(bus.gnt != '0));
      if (!bus.fsm_cmd_vld) check("fsm_cmd_zero_when_invalid", int'(bus.fsm_cmd), 0);
      check("done_err_exclusive", int'(bus.done & bus.err), 0);
      if (active && bus.gnt != gprev) begin
        active = 1'b0;
        check("gnt_winner", int'(gprev), 1 << cur.win);
        check("gnt_len", glen, cur.glen);
        check("vld_len", vlen, cur.vlen);
        check("grant_latency", st, cur.start);
        check("result_done", int'(sdone), int'(cur.ok));
        check("result_err", int'(serr), int'(!cur.ok));
        check("pulse_count", npulse, 1);
        check("pulse_in_last_gnt_cycle", ppos, glen);
        $display("[TB] txn req%0d cmd=%0d gnt_cycles=%0d result=%s", cur.win, cur.cmd, glen,
                 sdone ? "done" : (serr ? "err" : "none"));
        if (bus.gnt != '0) check("idle_gap_between_grants", int'(bus.gnt), 0);
      end
      if (!active && bus.gnt != '0 && gprev == '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_grant", int'(bus.gnt), 0);
        end else begin
          cur = exp_q.pop_front();
          active = 1'b1;
          glen = 0; vlen = 0; npulse = 0; ppos = 0; sdone = 1'b0; serr = 1'b0; st = cyc;
        end
      end
      if (active) begin
        glen++;
        if (bus.fsm_cmd_vld) begin
          vlen++;
          check("fsm_cmd_value", int'(bus.fsm_cmd), cur.cmd);
        end
        if (bus.done || bus.err) begin
          npulse++;
          ppos = glen;
          sdone |= bus.done;
          serr  |= bus.err;
        end
      end else begin
        check("stray_pulse", int'(bus.done | bus.err), 0);
        check("stray_vld", int'(bus.fsm_cmd_vld), 0);
      end
      gprev = bus.gnt;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*W-1:0] cv;
    int             d, r;
    bus.req = '0;
    bus.cmd = '0;
    repeat (3) @(negedge clk);
    check("init_gnt",  int'(bus.gnt), 0);
    check("init_vld",  int'(bus.fsm_cmd_vld), 0);
    check("init_cmd",  int'(bus.fsm_cmd), 0);
    check("init_done", int'(bus.done), 0);
    check("init_err",  int'(bus.err), 0);
    check("init_busy", int'(bus.busy), 0);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Single requester, FSM follows the command: fastest done.
    cv = '0; cv[2:0] = 3'd2;
    issue(4'b0001, cv, 0);
    bus.req = '0;

    // All requesters held: order 0,1,2,3,0 from a freshly reset pointer.
    do_reset();
    cv = {3'd1, 3'd3, 3'd0, 3'd2};
    repeat (5) issue(4'b1111, cv, 0);
    bus.req = '0;

    // Illegal command is rejected without driving the FSM.
    cv = '0; cv[8:6] = 3'd5;
    issue(4'b0100, cv, 0);
    bus.req = '0;

    // FSM stuck: timeout after TO WAIT cycles, then a normal request.
    cv = '0; cv[11:9] = 3'd3;
    issue(4'b1000, cv, 100);
    cv = '0; cv[2:0] = 3'd1;
    issue(4'b0001, cv, 0);
    bus.req = '0;

    // Match exactly on the last WAIT cycle, one past it, and one before it.
    cv = '0; cv[8:6] = 3'd2;
    issue(4'b0100, cv, TO - 1);
    cv = '0; cv[5:3] = 3'd1;
    issue(4'b0010, cv, TO);
    cv = '0; cv[8:6] = 3'd0;
    issue(4'b0100, cv, TO - 2);
    bus.req = '0;

    // Randomised traffic.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < N; i++) cv[i*W +: W] = W'($urandom_range(0, 7));
      r = $urandom_range(0, 9);
      if (r < 5)      d = $urandom_range(0, 3);
      else if (r < 8) d = $urandom_range(4, 16);
      else            d = 100;
      issue(N'($urandom_range(1, (1 << N) - 1)), cv, d);
    end
    bus.req = '0;

    // Reset in the middle of WAIT, after the pointer has moved away from 0.
    cv = '0; cv[2:0] = 3'd1; cv[8:6] = 3'd2;
    issue(4'b0100, cv, 0);
    cv = '0; cv[5:3] = 3'd1;
    push_txn(4'b0010, cv, 100);
    repeat (HOLD + 6) @(negedge clk);
    bus.req = '0;
    do_reset();
    cv = {3'd2, 3'd1, 3'd0, 3'd3};
    issue(4'b1111, cv, 0);
    bus.req = '0;

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
